// File: rtl/reg_scan_ctrl.sv
// Board controller: switch-written register file with debounced buttons and an AUTO/MANUAL display-scan read port.
// Optional write-through forwarding on both read ports when REG_BYPASS_EN is defined.
module reg_scan_ctrl #(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 2,
  parameter int TICK_LIMIT   = 50_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sw_waddr,
  input  logic [DATA_W-1:0] sw_wdata,
  input  logic [ADDR_W-1:0] sw_raddr1,
  input  logic              btn_wr,
  input  logic              btn_mode,
  input  logic              btn_step,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [ADDR_W-1:0] scan_addr,
  output logic              manual,
  output logic              wr_pulse
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int TICK_W = $clog2(TICK_LIMIT);
  localparam int NBTN   = 3;

  typedef enum logic {
    ST_AUTO   = 1'b0,
    ST_MANUAL = 1'b1
  } scan_state_t;

  // Button lanes: bit 0 = write, bit 1 = mode, bit 2 = step.
  logic [NBTN-1:0]   w_btn_raw;
  logic [NBTN-1:0]   r_sync1, r_sync2, r_db, r_db_d;
  logic [CNT_W-1:0]  r_cnt [NBTN];
  logic [NBTN-1:0]   w_edge;
  logic              w_wr_edge, w_mode_edge, w_step_edge;

  logic [DATA_W-1:0] r_regs [DEPTH];

  scan_state_t       r_state, w_state_nxt;
  logic [TICK_W-1:0] r_tick, w_tick_nxt;
  logic [ADDR_W-1:0] r_scan, w_scan_nxt;

  assign w_btn_raw = {btn_step, btn_mode, btn_wr};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int i = 0; i < NBTN; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < NBTN; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DEBOUNCE_CYC)) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_edge      = r_db & ~r_db_d;
  assign w_wr_edge   = w_edge[0];
  assign w_mode_edge = w_edge[1];
  assign w_step_edge = w_edge[2];

  // NOTE: the array is tiny, so it is reset like any other register; entry 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_edge && (sw_waddr != '0)) begin
      r_regs[sw_waddr] <= sw_wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = (a == '0) ? '0 : r_regs[a];
`ifdef REG_BYPASS_EN
    if (w_wr_edge && (a == sw_waddr) && (a != '0)) v = sw_wdata;
`endif
    return v;
  endfunction

  assign rdata1 = read_port(sw_raddr1);
  assign rdata2 = read_port(r_scan);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_AUTO;
      r_tick  <= '0;
      r_scan  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_scan  <= w_scan_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_scan_nxt  = r_scan;
    case (r_state)
      ST_AUTO: begin
        if (r_tick == TICK_W'(TICK_LIMIT - 1)) begin
          w_tick_nxt = '0;
          w_scan_nxt = r_scan + ADDR_W'(1);
        end else begin
          w_tick_nxt = r_tick + TICK_W'(1);
        end
        if (w_mode_edge) begin
          w_state_nxt = ST_MANUAL;
          w_tick_nxt  = '0;
        end
      end
      ST_MANUAL: begin
        w_tick_nxt = '0;
        // Mode wins over a coincident step.
        if (w_mode_edge)      w_state_nxt = ST_AUTO;
        else if (w_step_edge) w_scan_nxt  = r_scan + ADDR_W'(1);
      end
      default: w_state_nxt = ST_AUTO;
    endcase
  end

  assign scan_addr = r_scan;
  assign manual    = (r_state == ST_MANUAL);
  assign wr_pulse  = w_wr_edge;

endmodule

// File: tb/tb_reg_scan_ctrl.sv
// Directed bench for reg_scan_ctrl with DATA_W=4, ADDR_W=2, TICK_LIMIT=4, DEBOUNCE_CYC=2.
module tb_reg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sw_waddr, sw_raddr1;
  logic [3:0] sw_wdata;
  logic       btn_wr, btn_mode, btn_step;
  logic [3:0] rdata1, rdata2;
  logic [1:0] scan_addr;
  logic       manual, wr_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_mem [4];

  reg_scan_ctrl #(
    .DATA_W(4), .ADDR_W(2), .TICK_LIMIT(4), .DEBOUNCE_CYC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .sw_waddr(sw_waddr), .sw_wdata(sw_wdata), .sw_raddr1(sw_raddr1),
    .btn_wr(btn_wr), .btn_mode(btn_mode), .btn_step(btn_step),
    .rdata1(rdata1), .rdata2(rdata2), .scan_addr(scan_addr),
    .manual(manual), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_wr(input int hold, input int rest, output int pulses);
    pulses = 0;
    btn_wr = 1'b1;
    repeat (hold) begin @(negedge clk); if (wr_pulse === 1'b1) pulses++; end
    btn_wr = 1'b0;
    repeat (rest) begin @(negedge clk); if (wr_pulse === 1'b1) pulses++; end
  endtask

  task automatic press_btn(input int which);
    if (which == 1) btn_mode = 1'b1; else btn_step = 1'b1;
    idle(6);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    idle(8);
  endtask

  task automatic test_reset;
    idle(3);
    n_cmp++; if (scan_addr !== 2'd0) begin n_bad++; $display("FAIL reset_scan: got %0d expected 0", scan_addr); end
    n_cmp++; if (manual !== 1'b0) begin n_bad++; $display("FAIL reset_manual: got %b expected 0", manual); end
    n_cmp++; if (rdata1 !== 4'h0) begin n_bad++; $display("FAIL reset_rdata1: got %h expected 0", rdata1); end
    n_cmp++; if (rdata2 !== 4'h0) begin n_bad++; $display("FAIL reset_rdata2: got %h expected 0", rdata2); end
    n_cmp++; if (wr_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_wr_pulse: got %b expected 0", wr_pulse); end
  endtask

  task automatic test_auto_scan;
    logic [1:0] e;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = 2'((k / 4) % 4);
      n_cmp++; if (scan_addr !== e) begin n_bad++; $display("FAIL auto_scan k=%0d: got %0d expected %0d", k, scan_addr, e); end
      n_cmp++; if (rdata2 !== exp_mem[e]) begin n_bad++; $display("FAIL auto_rdata2 k=%0d: got %h expected %h", k, rdata2, exp_mem[e]); end
    end
    n_cmp++; if (manual !== 1'b0) begin n_bad++; $display("FAIL auto_manual: got %b expected 0", manual); end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [3:0] d);
    int p;
    sw_waddr = a;
    sw_wdata = d;
    press_wr(10, 8, p);
    n_cmp++; if (p != 1) begin n_bad++; $display("FAIL write_pulses addr=%0d: got %0d expected 1", a, p); end
    if (a != 2'd0) exp_mem[a] = d;
  endtask

  task automatic test_write_read;
    do_write(2'd2, 4'hA);
    sw_raddr1 = 2'd2; #1;
    n_cmp++; if (rdata1 !== 4'hA) begin n_bad++; $display("FAIL read_addr2: got %h expected a", rdata1); end
    do_write(2'd1, 4'h6);
    do_write(2'd3, 4'hC);
    do_write(2'd0, 4'hF);
    sw_raddr1 = 2'd0; #1;
    n_cmp++; if (rdata1 !== 4'h0) begin n_bad++; $display("FAIL read_addr0: got %h expected 0", rdata1); end
    sw_raddr1 = 2'd1; #1;
    n_cmp++; if (rdata1 !== 4'h6) begin n_bad++; $display("FAIL read_addr1: got %h expected 6", rdata1); end
    sw_raddr1 = 2'd3; #1;
    n_cmp++; if (rdata1 !== 4'hC) begin n_bad++; $display("FAIL read_addr3: got %h expected c", rdata1); end
  endtask

  task automatic test_bounce;
    int p;
    p = 0;
    sw_waddr = 2'd2;
    sw_wdata = 4'h3;
    for (int i = 0; i < 8; i++) begin
      btn_wr = (i % 2 == 0);
      @(negedge clk);
      if (wr_pulse === 1'b1) p++;
    end
    btn_wr = 1'b0;
    repeat (10) begin @(negedge clk); if (wr_pulse === 1'b1) p++; end
    n_cmp++; if (p != 0) begin n_bad++; $display("FAIL bounce_pulses: got %0d expected 0", p); end
    sw_raddr1 = 2'd2; #1;
    n_cmp++; if (rdata1 !== 4'hA) begin n_bad++; $display("FAIL bounce_reg: got %h expected a", rdata1); end
  endtask

  task automatic test_manual;
    logic [1:0] s0, s1, e;
    bit found;
    press_btn(1);
    n_cmp++; if (manual !== 1'b1) begin n_bad++; $display("FAIL manual_enter: got %b expected 1", manual); end
    s0 = scan_addr;
    idle(8);
    n_cmp++; if (scan_addr !== s0) begin n_bad++; $display("FAIL manual_frozen: got %0d expected %0d", scan_addr, s0); end
    n_cmp++; if (rdata2 !== exp_mem[s0]) begin n_bad++; $display("FAIL manual_rdata2: got %h expected %h", rdata2, exp_mem[s0]); end
    for (int j = 1; j <= 3; j++) begin
      press_btn(2);
      e = s0 + 2'(j);
      n_cmp++; if (scan_addr !== e) begin n_bad++; $display("FAIL manual_step%0d: got %0d expected %0d", j, scan_addr, e); end
      n_cmp++; if (rdata2 !== exp_mem[e]) begin n_bad++; $display("FAIL step_rdata2 %0d: got %h expected %h", j, rdata2, exp_mem[e]); end
    end
    btn_mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (manual === 1'b0) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL manual_exit: manual stayed 1, expected 0 within 20 cycles"); end
    s1 = scan_addr;
    e = s0 + 2'd3;
    n_cmp++; if (s1 !== e) begin n_bad++; $display("FAIL scan_kept: got %0d expected %0d", s1, e); end
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      e = (n == 4) ? s1 + 2'd1 : s1;
      n_cmp++; if (scan_addr !== e) begin n_bad++; $display("FAIL auto_resume n=%0d: got %0d expected %0d", n, scan_addr, e); end
    end
    btn_mode = 1'b0;
    idle(10);
  endtask

  task automatic test_simultaneous;
    logic [1:0] s;
    bit found;
    press_btn(1);
    n_cmp++; if (manual !== 1'b1) begin n_bad++; $display("FAIL simul_pre: got %b expected 1", manual); end
    s = scan_addr;
    btn_mode = 1'b1;
    btn_step = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (manual === 1'b0) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL simul_toggle: manual stayed 1, expected 0 within 20 cycles"); end
    n_cmp++; if (scan_addr !== s) begin n_bad++; $display("FAIL simul_step_ignored: got %0d expected %0d", scan_addr, s); end
    idle(2);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    idle(10);
    n_cmp++; if (manual !== 1'b0) begin n_bad++; $display("FAIL simul_one_toggle: got %b expected 0", manual); end
    press_btn(1);
    n_cmp++; if (manual !== 1'b1) begin n_bad++; $display("FAIL simul_reenter: got %b expected 1", manual); end
  endtask

  task automatic test_bypass;
    logic [3:0] exp_commit;
    bit found;
`ifdef REG_BYPASS_EN
    exp_commit = 4'h5;
`else
    exp_commit = exp_mem[3];
`endif
    sw_waddr  = 2'd3;
    sw_wdata  = 4'h5;
    sw_raddr1 = 2'd3;
    btn_wr    = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_pulse === 1'b1) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL bypass_pulse: no wr_pulse within 20 cycles"); end
    n_cmp++; if (rdata1 !== exp_commit) begin n_bad++; $display("FAIL commit_cycle_rdata1: got %h expected %h", rdata1, exp_commit); end
    @(negedge clk);
    n_cmp++; if (wr_pulse !== 1'b0) begin n_bad++; $display("FAIL pulse_width: got %b expected 0", wr_pulse); end
    n_cmp++; if (rdata1 !== 4'h5) begin n_bad++; $display("FAIL after_commit_rdata1: got %h expected 5", rdata1); end
    exp_mem[3] = 4'h5;
    btn_wr = 1'b0;
    idle(10);
  endtask

  task automatic test_async_reset;
    sw_raddr1 = 2'd2;
    btn_wr = 1'b1;
    idle(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (scan_addr !== 2'd0) begin n_bad++; $display("FAIL async_scan: got %0d expected 0", scan_addr); end
    n_cmp++; if (manual !== 1'b0) begin n_bad++; $display("FAIL async_manual: got %b expected 0", manual); end
    n_cmp++; if (rdata1 !== 4'h0) begin n_bad++; $display("FAIL async_rdata1: got %h expected 0", rdata1); end
    n_cmp++; if (rdata2 !== 4'h0) begin n_bad++; $display("FAIL async_rdata2: got %h expected 0", rdata2); end
    n_cmp++; if (wr_pulse !== 1'b0) begin n_bad++; $display("FAIL async_wr_pulse: got %b expected 0", wr_pulse); end
    btn_wr = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    rst       = 1'b1;
    sw_waddr  = '0;
    sw_wdata  = '0;
    sw_raddr1 = '0;
    btn_wr    = 1'b0;
    btn_mode  = 1'b0;
    btn_step  = 1'b0;
    for (int i = 0; i < 4; i++) exp_mem[i] = 4'h0;

    test_reset;
    test_auto_scan;
    test_write_read;
    test_bounce;
    test_manual;
    test_simultaneous;
    test_bypass;
    test_async_reset;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_scan_ctrl.md
Name: reg_scan_ctrl

Overview:
Parametrised register-file board controller: an internal 2^ADDR_W x DATA_W register file, written from switches on a debounced button press, plus a display-scan read port.
- Scan port advances automatically every TICK_LIMIT cycles (AUTO) or on a debounced step button (MANUAL).
- Sits between raw board I/O and the LED/seven-segment drivers; generalises the fixed 4x4 board demo in width, depth and scan mode.

Parameters:
DATA_W, 4, register data width
ADDR_W, 2, address width; depth = 2^ADDR_W
TICK_LIMIT, 50_000_000, AUTO scan period in clk cycles (>=2)
DEBOUNCE_CYC, 1_000_000, cycles a synced button level must be stable before it is accepted (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
sw_waddr  in  ADDR_W  write address
sw_wdata  in  DATA_W  write data
sw_raddr1  in  ADDR_W  read port 1 address
btn_wr  in  1  raw write button
btn_mode  in  1  raw AUTO/MANUAL toggle button
btn_step  in  1  raw manual-step button
rdata1  out  DATA_W  data at sw_raddr1
rdata2  out  DATA_W  data at scan_addr
scan_addr  out  ADDR_W  current scan address, for the digit display
manual  out  1  0=AUTO, 1=MANUAL
wr_pulse  out  1  one-cycle strobe when a write commits

Behaviour:
- Reset (async, any time, including mid-scan or mid-debounce):
  - All registers cleared to 0, scan_addr=0, manual=0, tick counter=0.
  - Debounced levels=0, sync flops=0, wr_pulse=0.
- Button path, per button:
  - 2-flop synchroniser feeds a debounce counter. While the synced level differs from the debounced level, the counter increments; any cycle it matches, the counter clears.
  - When the counter reaches DEBOUNCE_CYC, the debounced level takes the synced level and the counter clears.
  - A rising debounced level generates a one-cycle edge pulse. No pulse on release; a held button yields exactly one pulse.
  - Nominal raw-rise to pulse latency: DEBOUNCE_CYC+3 cycles.
- Write:
  - On the btn_wr edge pulse, reg[sw_waddr] <= sw_wdata at the next edge; wr_pulse is high for that same cycle.
  - Address 0 is hardwired: writes are ignored (wr_pulse still fires) and reads of address 0 return 0.
- Reads: combinational from the array. rdata1=reg[sw_raddr1], rdata2=reg[scan_addr].
- Scan FSM, states AUTO(manual=0) and MANUAL(manual=1):
  - AUTO: tick counter counts 0..TICK_LIMIT-1. In the cycle it equals TICK_LIMIT-1 it returns to 0 and scan_addr increments.
  - MANUAL: tick counter held at 0; each btn_step edge increments scan_addr.
  - btn_mode edge toggles state. Entering AUTO clears the tick counter, so the first advance comes TICK_LIMIT cycles later. scan_addr is preserved across toggles.
  - scan_addr wraps 2^ADDR_W-1 -> 0 (modulo arithmetic, no saturation).
- Simultaneous events:
  - Mode edge and step edge in the same cycle: mode toggles, step is ignored.
  - Step edge in AUTO is ignored.
  - A write and a scan advance in the same cycle proceed independently.

Optional Feature:
REG_BYPASS_EN:
- Defined: write-through forwarding. In the cycle a write commits to address A≠0, any read port addressing A returns sw_wdata combinationally.
- Undefined: read ports return the old value until the clock edge after the write.

Test Plan:
All scenarios use DATA_W=4, ADDR_W=2, TICK_LIMIT=4, DEBOUNCE_CYC=2.
1. Reset: assert rst mid-operation, asynchronously, between edges -> scan_addr=0, manual=0, rdata1=rdata2=0, wr_pulse=0 immediately.
2. Write and read: sw_waddr=2, sw_wdata=4'hA, press btn_wr for 10 cycles -> exactly one wr_pulse; rdata1=4'hA with sw_raddr1=2. A write to address 0 with 4'hF -> rdata1=0 with sw_raddr1=0.
3. Bounce: btn_wr toggles high/low each cycle for 8 cycles, then stays low -> no wr_pulse, register unchanged.
4. AUTO scan: from reset, no input -> scan_addr goes 0,1,2,3,0 with a 4-cycle period; rdata2 tracks reg[scan_addr].
5. MANUAL: press btn_mode -> manual=1, scan_addr frozen; three btn_step presses -> scan_addr +3 mod 4. Press btn_mode again -> manual=0 and the first advance comes 4 cycles later.
6. Simultaneous mode and step presses: one toggle, no step. With REG_BYPASS_EN, a write 4'h5 to the address on sw_raddr1 -> rdata1=5 in the commit cycle; without it -> 5 on the following cycle.
